apb_arbiter_master: RTL
=======================

APB_ARBITER_MASTER -- requirements
Module: apb_arbiter_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the clock port is named clk and the reset port is named rst.
REQ-002 Parameter TIMEOUT SHALL default to 15 and set the maximum number of PREADY=0 cycles tolerated in ACCESS.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  async active-high reset.
- req  in  2  per-requester transfer request; held high until done.
- addr  in  2x32  per-requester address.
- wdata  in  2x32  per-requester write data.
- write  in  2  per-requester direction; 1=write.
- done  out  2  one-cycle completion pulse to the owning requester.
- err  out  1  error status; valid with any done bit.
- rdata  out  32  read data; valid with any done bit.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Function
REQ-004 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-005 In IDLE with any req bit high at a clock edge, the FSM SHALL go to SETUP and latch the winner's addr, wdata and write into PADDR, PWDATA and PWRITE.
REQ-006 Arbitration SHALL be round-robin: a sole requester wins; with both requesting, the requester not granted last wins.
REQ-007 The last-grant pointer SHALL reset to 1, so that requester 0 wins the first tie.
REQ-008 In SETUP, PSEL SHALL be 1 and PENABLE 0, and the FSM SHALL go unconditionally to ACCESS on the next edge.
REQ-009 In ACCESS, PSEL and PENABLE SHALL both be 1, and PADDR, PWDATA and PWRITE SHALL stay stable.
REQ-010 When PREADY=1 in ACCESS, on that edge:
- FSM goes to IDLE;
- PSEL and PENABLE go to 0;
- done[owner] is 1 for exactly the following cycle;
- rdata captures PRDATA on reads, and is 0 on writes;
- err captures PSLVERR.
REQ-011 A wait-state counter SHALL increment on each ACCESS cycle with PREADY=0, and clear on entry to SETUP.
REQ-012 When the wait-state counter reaches TIMEOUT while PREADY=0, the block SHALL end the transfer as in REQ-010, but with err=1 and rdata=0.
REQ-013 A minimum of one IDLE cycle SHALL separate consecutive transfers, so PSEL is low for at least one cycle between transfers.
REQ-014 Deassertion of req during SETUP or ACCESS SHALL be ignored: the transfer completes and done still pulses.
REQ-015 A requester whose req is still high in the cycle its done pulses SHALL be treated as a new request in IDLE on the following edge.
REQ-016 At most one done bit SHALL be high in any cycle.
REQ-017 Outside the done cycle, err and rdata SHALL hold their last values.

Reset
REQ-018 While rst=1, immediately and regardless of clk:
- FSM = IDLE;
- PSEL, PENABLE, PWRITE, PADDR, PWDATA, done, err and rdata = 0;
- wait counter = 0;
- last-grant pointer = 1.
REQ-019 Reset asserted during SETUP or ACCESS SHALL abort the transfer with no done pulse.
REQ-020 After rst is released, the first transfer SHALL start from IDLE.

Verification
REQ-021 Single write: req=01, addr0=0x80000004, wdata0=0xDEADBEEF, write0=1, PREADY=1 -> SETUP then ACCESS with PADDR=0x80000004, PWDATA=0xDEADBEEF, PWRITE=1; done=01 on the next cycle; err=0.
REQ-022 Read with 2 wait states: req=10, addr1=0x80000010, write1=0, PRDATA=0x12345678, PREADY low for 2 ACCESS cycles then high -> ACCESS lasts 3 cycles; done=10 with rdata=0x12345678 and err=0.
REQ-023 Contention: req=11 held continuously with PREADY=1 -> grant order 0,1,0,1; each transfer takes SETUP, ACCESS and one IDLE cycle; done pulses alternate 01,10.
REQ-024 Timeout: PREADY stuck at 0, TIMEOUT=15 -> after 15 wait cycles PSEL=0; done[owner]=1, err=1, rdata=0.
REQ-025 Slave error: PSLVERR=1 with PREADY=1 on a read with PRDATA=0xA5A5A5A5 -> done pulses with err=1 and rdata=0xA5A5A5A5.
REQ-026 Reset mid-ACCESS: assert rst between clock edges -> PSEL and PENABLE drop to 0 before the next edge; no done pulse; after release, req=01 -> a normal transfer.

Source files
------------

// File: rtl/apb_arbiter_master.sv
// rtl/apb_arbiter_master.sv - two-requester round-robin arbiter driving a single APB master port
module apb_arbiter_master #(
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0][31:0] addr,
    input  logic [1:0][31:0] wdata,
    input  logic [1:0]       write,
    output logic [1:0]       done,
    output logic             err,
    output logic [31:0]      rdata,
    output logic [31:0]      PADDR,
    output logic [31:0]      PWDATA,
    output logic             PWRITE,
    output logic             PSEL,
    output logic             PENABLE,
    input  logic [31:0]      PRDATA,
    input  logic             PREADY,
    input  logic             PSLVERR
);

    // Wide enough to hold TIMEOUT itself, never narrower than one bit.
    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_last;
    logic            r_owner;
    logic [WW-1:0]   r_wait;

    logic            w_grant;
    logic            w_winner;
    logic            w_complete;
    logic            w_timeout;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not granted last.
    always_comb begin
        w_grant  = |req;
        w_winner = 1'b0;
        if (req == 2'b11) begin
            w_winner = ~r_last;
        end else begin
            w_winner = req[1];
        end
    end

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, completion/timeout detection and APB strobes decoded from the state.
    always_comb begin
        w_next     = r_state;
        w_complete = 1'b0;
        w_timeout  = 1'b0;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                PSEL   = 1'b1;
                w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    w_complete = 1'b1;
                    w_next     = ST_IDLE;
                end else if ((int'(r_wait) + 1) >= TIMEOUT) begin
                    // This stalled cycle is the TIMEOUT-th one: give up on the slave.
                    w_complete = 1'b1;
                    w_timeout  = 1'b1;
                    w_next     = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Grant bookkeeping, APB address/data latching, wait counting and completion status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_wait  <= '0;
            PADDR   <= 32'h0;
            PWDATA  <= 32'h0;
            PWRITE  <= 1'b0;
            done    <= 2'b00;
            err     <= 1'b0;
            rdata   <= 32'h0;
        end else begin
            done <= 2'b00;

            if ((r_state == ST_IDLE) && w_grant) begin
                PADDR   <= addr[w_winner];
                PWDATA  <= wdata[w_winner];
                PWRITE  <= write[w_winner];
                r_owner <= w_winner;
                r_last  <= w_winner;
                r_wait  <= '0;
            end

            if ((r_state == ST_ACCESS) && !PREADY && !w_timeout) begin
                r_wait <= r_wait + WW'(1);
            end

            // err/rdata only change on completion so they hold between transfers.
            if (w_complete) begin
                done  <= r_owner ? 2'b10 : 2'b01;
                err   <= w_timeout ? 1'b1 : PSLVERR;
                rdata <= (w_timeout || PWRITE) ? 32'h0 : PRDATA;
            end
        end
    end

endmodule
